// File: rtl/uart_word_rx_pkg.sv
// Shared types and constants for the uart_word_rx receive path.
// Optional parity checking is enabled with `define UART_RX_PARITY_EN.
package uart_word_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int ERR_OVR = 0;
    localparam int ERR_FRM = 1;
    localparam int ERR_TMO = 2;
    localparam int ERR_PAR = 3;

    localparam logic [15:0] MIN_DIV = 16'd4;

    // Clamp the runtime divisor so the half-bit count never collapses.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_word_rx_byte.sv
// UART byte deserialiser: 2-flop synchroniser, bit-timing FSM, shift register.
// With `define UART_RX_PARITY_EN a parity bit is checked between data and stop.
module uart_byte_rx
    import uart_word_rx_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        sig,
    input  logic [15:0] baud_div,
`ifdef UART_RX_PARITY_EN
    input  logic        parity_odd,
`endif
    output logic [7:0]  rx_byte,
    output logic        byte_valid,
    output logic        frame_err,
    output logic        parity_err
);

    rx_state_t   r_state;
    rx_state_t   w_next;
    logic [1:0]  r_sync;
    logic        r_prev;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_byte;
    logic        r_valid;
    logic        r_ferr;
    logic        r_perr;
    logic        r_par_bad;

    logic        w_line;
    logic        w_fall;
    logic        w_half_hit;
    logic        w_full_hit;
    logic        w_start;
    logic        w_cnt_clr;
    logic        w_shift;
    logic        w_par_chk;
    logic        w_par_mis;
    logic        w_stop_ok;
    logic        w_stop_bad;

    assign w_line     = r_sync[1];
    assign w_fall     = r_prev & ~w_line;
    assign w_half_hit = (r_cnt == ({1'b0, r_div[15:1]} - 16'd1));
    assign w_full_hit = (r_cnt == (r_div - 16'd1));

`ifdef UART_RX_PARITY_EN
    assign w_par_mis = (w_line != (^r_shift ^ parity_odd));
`else
    assign w_par_mis = 1'b0;
`endif

    // Bring the asynchronous line into the clock domain; keep last value for edge detect.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], sig};
            r_prev <= r_sync[1];
        end
    end

    // Receiver state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-cycle strobes for bit timing.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_cnt_clr  = 1'b0;
        w_shift    = 1'b0;
        w_par_chk  = 1'b0;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_start   = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_next    = START;
                end
            end
            START: begin
                if (w_half_hit) begin
                    w_cnt_clr = 1'b1;
                    w_next    = w_line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_full_hit) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_next = PARITY;
`else
                        w_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_full_hit) begin
                    w_cnt_clr = 1'b1;
                    w_par_chk = 1'b1;
                    w_next    = STOP;
                end
            end
`endif
            STOP: begin
                if (w_full_hit) begin
                    w_cnt_clr = 1'b1;
                    if (w_line) begin
                        w_stop_ok = 1'b1;
                        w_next    = IDLE;
                    end else begin
                        w_stop_bad = 1'b1;
                        w_next     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_line) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Bit counter, latched divisor and data shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div     <= MIN_DIV;
            r_cnt     <= 16'd0;
            r_bit     <= 3'd0;
            r_shift   <= 8'd0;
            r_par_bad <= 1'b0;
        end else begin
            if (w_start) begin
                r_div     <= eff_div(baud_div);
                r_bit     <= 3'd0;
                r_par_bad <= 1'b0;
            end
            if (w_cnt_clr) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_shift) begin
                r_shift <= {w_line, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (w_par_chk) begin
                r_par_bad <= w_par_mis;
            end
        end
    end

    // Registered single-cycle result pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_byte  <= 8'd0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_valid <= w_stop_ok & ~r_par_bad;
            r_ferr  <= w_stop_bad;
            r_perr  <= w_par_chk & w_par_mis;
            if (w_stop_ok) begin
                r_byte <= r_shift;
            end
        end
    end

    assign rx_byte    = r_byte;
    assign byte_valid = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: byte deserialiser, word assembler with timeout, FWFT FIFO.
// Define UART_RX_PARITY_EN to add the parity_odd input and parity checking.
module uart_word_rx
    import uart_word_rx_pkg::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int DEPTH       = 64,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sig,
    input  logic [15:0]            baud_div,
    input  logic                   msb_first,
    input  logic                   read_req,
    input  logic                   clear_err,
`ifdef UART_RX_PARITY_EN
    input  logic                   parity_odd,
`endif
    output logic [WORD_SIZE-1:0]   data_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [3:0]             err
);

    localparam int NB = WORD_SIZE / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] LAST = IW'(NB - 1);

    logic [7:0]           w_byte;
    logic                 w_bv;
    logic                 w_ferr;
    logic                 w_perr;

    logic [IW-1:0]        r_idx;
    logic                 r_msb;
    logic [WORD_SIZE-1:0] r_word;
    logic [TW-1:0]        r_tmo;
    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic [3:0]           r_err;

    logic                 w_msb;
    logic [IW-1:0]        w_lane;
    logic                 w_last;
    logic [WORD_SIZE-1:0] w_word;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ovr;
    logic                 w_tmo_fire;
    logic [3:0]           w_err_set;

    uart_byte_rx u_byte (
        .clock      (clock),
        .reset      (reset),
        .sig        (sig),
        .baud_div   (baud_div),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .rx_byte    (w_byte),
        .byte_valid (w_bv),
        .frame_err  (w_ferr),
        .parity_err (w_perr)
    );

    assign w_msb      = (r_idx == '0) ? msb_first : r_msb;
    assign w_lane     = w_msb ? (LAST - r_idx) : r_idx;
    assign w_last     = (r_idx == LAST);
    assign w_push_req = w_bv & w_last;
    assign w_pop      = read_req & ~empty;
    assign w_push     = w_push_req & (~full | read_req);
    assign w_ovr      = w_push_req & ~w_push;
    assign w_tmo_fire = (r_idx != '0) & ~w_bv
                      & (r_tmo == TW'(TIMEOUT_CYC));

    // Drop the incoming byte into its lane of the word under assembly.
    always_comb begin
        w_word = r_word;
        for (int k = 0; k < NB; k++) begin
            if (w_lane == IW'(k)) begin
                w_word[k*8 +: 8] = w_byte;
            end
        end
    end

    // Byte index, byte order latch and partial-word timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx  <= '0;
            r_msb  <= 1'b0;
            r_word <= '0;
            r_tmo  <= '0;
        end else if (w_bv) begin
            r_word <= w_word;
            r_tmo  <= '0;
            if (r_idx == '0) begin
                r_msb <= msb_first;
            end
            r_idx <= w_last ? '0 : r_idx + IW'(1);
        end else if (w_tmo_fire) begin
            r_idx <= '0;
            r_tmo <= '0;
        end else if (r_idx != '0) begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    // Word storage; the completed word is written in the cycle of its last byte.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // Ring-buffer pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Gather this cycle's error events by bit position.
    always_comb begin
        w_err_set          = 4'b0000;
        w_err_set[ERR_OVR] = w_ovr;
        w_err_set[ERR_FRM] = w_ferr;
        w_err_set[ERR_TMO] = w_tmo_fire;
        w_err_set[ERR_PAR] = w_perr;
    end

    // Sticky errors; a new event wins over a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 4'b0000;
        end else begin
            r_err <= (clear_err ? 4'b0000 : r_err) | w_err_set;
        end
    end

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign err      = r_err;
    assign data_out = empty ? '0 : r_mem[r_rptr];

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed testbench for uart_word_rx (WORD_SIZE=32, DEPTH=4, TIMEOUT_CYC=1000).
// Serial frames are driven on the falling clock edge; outputs are sampled there too.
module tb_uart_word_rx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sig = 1'b1;
    logic [15:0] baud_div = 16'd16;
    logic        msb_first = 1'b0;
    logic        read_req = 1'b0;
    logic        clear_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic        parity_odd = 1'b0;
`endif
    logic [31:0] data_out;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic [3:0]  err;

    int checks = 0;
    int errors = 0;
    int bit_div = 16;

    uart_word_rx #(
        .WORD_SIZE   (32),
        .DEPTH       (4),
        .TIMEOUT_CYC (1000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sig        (sig),
        .baud_div   (baud_div),
        .msb_first  (msb_first),
        .read_req   (read_req),
        .clear_err  (clear_err),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .err        (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame. pop_at pulses read_req at that cycle of the stop bit;
    // probe checks empty just before and just after the push becomes visible.
    task automatic send_byte(input logic [7:0] b, input logic stop_v,
                             input int pop_at, input bit probe);
        logic [9:0] fr;
        fr = {stop_v, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < bit_div; c++) begin
                @(negedge clock);
                if (probe && i == 9 && c == 11) chk("lat_pre", 32'(empty), 32'd1);
                if (probe && i == 9 && c == 12) chk("lat_post", 32'(empty), 32'd0);
                sig = fr[i];
                read_req = (i == 9) && (c == pop_at);
            end
        end
        @(negedge clock);
        sig = 1'b1;
        read_req = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w, input int pop_at,
                             input bit probe);
        for (int j = 0; j < 4; j++) begin
            send_byte(w[8*j +: 8], 1'b1, (j == 3) ? pop_at : -1,
                      probe && (j == 3));
        end
    endtask

    task automatic pop();
        @(negedge clock);
        read_req = 1'b1;
        @(negedge clock);
        read_req = 1'b0;
    endtask

    task automatic clr();
        @(negedge clock);
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
    endtask

    function automatic logic [31:0] wv(input int i);
        return {8'(16*i+3), 8'(16*i+2), 8'(16*i+1), 8'(16*i)};
    endfunction

    initial begin
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_data", data_out, 32'd0);

        // LSB-first word with push latency probe
        send_word(32'h11223344, -1, 1'b1);
        chk("lsb_data", data_out, 32'h11223344);
        chk("lsb_count", 32'(count), 32'd1);
        chk("lsb_err", 32'(err), 32'd0);
        pop();
        chk("pop1_empty", 32'(empty), 32'd1);
        chk("pop1_count", 32'(count), 32'd0);

        // MSB-first word
        msb_first = 1'b1;
        send_word(32'h11223344, -1, 1'b0);
        chk("msb_data", data_out, 32'h44332211);
        chk("msb_count", 32'(count), 32'd1);
        pop();
        chk("pop2_empty", 32'(empty), 32'd1);
        chk("pop2_count", 32'(count), 32'd0);
        msb_first = 1'b0;

        // Overflow: five words into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_word(wv(i), -1, 1'b0);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_err", 32'(err), 32'b0001);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_head%0d", i), data_out, wv(i));
            pop();
        end
        chk("ovf_drained", 32'(empty), 32'd1);
        clr();
        chk("ovf_clr", 32'(err), 32'd0);

        // Push into a full FIFO while popping in the same cycle
        for (int i = 6; i <= 9; i++) send_word(wv(i), -1, 1'b0);
        chk("pp_full_before", 32'(full), 32'd1);
        send_word(wv(10), 11, 1'b0);
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_err", 32'(err), 32'd0);
        for (int i = 7; i <= 10; i++) begin
            chk($sformatf("pp_head%0d", i), data_out, wv(i));
            pop();
        end
        chk("pp_drained", 32'(empty), 32'd1);

        // Framing error on the second byte
        send_byte(8'h55, 1'b1, -1, 1'b0);
        send_byte(8'hAA, 1'b0, -1, 1'b0);
        send_byte(8'h66, 1'b1, -1, 1'b0);
        send_byte(8'h77, 1'b1, -1, 1'b0);
        send_byte(8'h88, 1'b1, -1, 1'b0);
        chk("frm_err", 32'(err), 32'b0010);
        chk("frm_data", data_out, 32'h88776655);
        chk("frm_count", 32'(count), 32'd1);
        pop();
        clr();
        chk("frm_clr", 32'(err), 32'd0);

        // Partial-word timeout
        send_byte(8'h01, 1'b1, -1, 1'b0);
        send_byte(8'h02, 1'b1, -1, 1'b0);
        repeat (900) @(negedge clock);
        chk("tmo_early", 32'(err), 32'd0);
        repeat (200) @(negedge clock);
        chk("tmo_err", 32'(err), 32'b0100);
        chk("tmo_empty", 32'(empty), 32'd1);
        send_word(32'hA4A3A2A1, -1, 1'b0);
        chk("tmo_data", data_out, 32'hA4A3A2A1);
        chk("tmo_count", 32'(count), 32'd1);
        pop();
        clr();

        // Divisor below minimum runs at 4 cycles per bit
        baud_div = 16'd2;
        bit_div = 4;
        send_word(32'hF00FC35A, -1, 1'b0);
        chk("div_data", data_out, 32'hF00FC35A);
        chk("div_err", 32'(err), 32'd0);
        pop();

        // One-cycle low glitch is rejected silently
        @(negedge clock);
        sig = 1'b0;
        @(negedge clock);
        sig = 1'b1;
        repeat (40) @(negedge clock);
        chk("gl_err", 32'(err), 32'd0);
        chk("gl_empty", 32'(empty), 32'd1);
        send_word(32'h78563412, -1, 1'b0);
        chk("gl_data", data_out, 32'h78563412);
        chk("gl_count", 32'(count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
